// File: rtl/key_debounce_multi.sv
// N-channel key debouncer: 2-flop sync, tick-sampled stability filter, press/release/long pulses.
// Optional auto-repeat of key_press while long-held is built when KEY_REPEAT_EN is defined.

module key_debounce_chan #(
  parameter int STABLE_N   = 3,
  parameter int LONG_TICKS = 50
`ifdef KEY_REPEAT_EN
  , parameter int REPEAT_TICKS = 10
`endif
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_deb,
  output logic o_press,
  output logic o_release,
  output logic o_long
);
  typedef enum logic [1:0] {S_REL, S_PRS, S_LNG} state_t;

  localparam int                HOLD_W   = (LONG_TICKS > 0) ? $clog2(LONG_TICKS + 1) : 1;
  localparam logic [3:0]        STB_TOP  = 4'(STABLE_N);
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(LONG_TICKS);

  state_t            r_state;
  logic [3:0]        r_stb;
  logic [HOLD_W-1:0] r_hold;
  logic              r_deb, r_press, r_release, r_long;
  logic              w_diff, w_accept;
  logic [3:0]        w_stb_nx;
  logic [HOLD_W-1:0] w_hold_nx;

  assign w_diff    = i_raw ^ r_deb;
  assign w_stb_nx  = r_stb + 4'd1;
  assign w_accept  = w_diff && (w_stb_nx == STB_TOP);
  assign w_hold_nx = r_hold + 1'b1;

`ifdef KEY_REPEAT_EN
  localparam int               REP_W   = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
  localparam logic [REP_W-1:0] REP_TOP = REP_W'(REPEAT_TICKS);
  logic [REP_W-1:0] r_rep, w_rep_nx;
  assign w_rep_nx = r_rep + 1'b1;
`endif

  // An accepted change always wins over hold/repeat bookkeeping in the same tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_REL;
      r_stb     <= '0;
      r_hold    <= '0;
      r_deb     <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_rep     <= '0;
`endif
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      if (i_tick) begin
        r_stb <= (w_diff && !w_accept) ? w_stb_nx : 4'd0;
        if (w_accept && r_state == S_REL) begin
          r_state <= S_PRS;
          r_deb   <= 1'b1;
          r_press <= 1'b1;
          r_hold  <= '0;
        end else if (w_accept) begin
          r_state   <= S_REL;
          r_deb     <= 1'b0;
          r_release <= 1'b1;
          r_hold    <= '0;
`ifdef KEY_REPEAT_EN
          r_rep     <= '0;
`endif
        end else if (r_state == S_PRS && LONG_TICKS > 0) begin
          if (w_hold_nx == HOLD_TOP) begin
            r_long  <= 1'b1;
            r_state <= S_LNG;
            r_hold  <= HOLD_TOP;
`ifdef KEY_REPEAT_EN
            r_rep   <= '0;
`endif
          end else begin
            r_hold <= w_hold_nx;
          end
        end
`ifdef KEY_REPEAT_EN
        else if (r_state == S_LNG && REPEAT_TICKS > 0) begin
          if (w_rep_nx == REP_TOP) begin
            r_press <= 1'b1;
            r_rep   <= '0;
          end else begin
            r_rep <= w_rep_nx;
          end
        end
`endif
      end
    end
  end

  assign o_deb     = r_deb;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;
endmodule

module key_debounce_multi #(
  parameter int N_KEYS       = 16,
  parameter int CNT_MAX      = 999_999,
  parameter int STABLE_N     = 3,
  parameter int LONG_TICKS   = 50,
  parameter int ACTIVE_LOW   = 1,
  parameter int REPEAT_TICKS = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_deb,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic              tick
);
  localparam int                DIV_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [DIV_W-1:0]  DIV_TOP = DIV_W'(CNT_MAX);
  localparam logic [N_KEYS-1:0] IDLE    = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

  if (STABLE_N < 1 || STABLE_N > 15 || REPEAT_TICKS < 0) begin : g_bad_cfg
    $error("key_debounce_multi: STABLE_N must be 1..15 and REPEAT_TICKS >= 0");
  end

  logic [DIV_W-1:0]  r_div;
  logic [N_KEYS-1:0] r_s1, r_s2;
  logic              w_tick;
  logic [N_KEYS-1:0] w_raw;

  assign w_tick = (r_div == DIV_TOP);
  assign tick   = w_tick;
  assign w_raw  = r_s2 ^ IDLE;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  // Synchronisers idle at the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1 <= IDLE;
      r_s2 <= IDLE;
    end else begin
      r_s1 <= key_in;
      r_s2 <= r_s1;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_chan #(
      .STABLE_N     (STABLE_N),
      .LONG_TICKS   (LONG_TICKS)
`ifdef KEY_REPEAT_EN
      , .REPEAT_TICKS (REPEAT_TICKS)
`endif
    ) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .i_tick    (w_tick),
      .i_raw     (w_raw[g]),
      .o_deb     (key_deb[g]),
      .o_press   (key_press[g]),
      .o_release (key_release[g]),
      .o_long    (key_long[g])
    );
  end
endmodule
